// File: rtl/generation_sequencer.sv
// Frame-sweep controller: walks calc_row through every grid row via a req/ack
// handshake, waits for the next-state pipeline to drain, then flips the frame bank.
module generation_sequencer #(
   parameter int ROWS         = 720,
   parameter int ROW_W        = 10,
   parameter int GEN_W        = 16,
   parameter int DRAIN_CYCLES = 3
) (
   input  logic             out_stream_aclk,
   input  logic             rst,
   input  logic             start,
   input  logic             mode,
   input  logic [GEN_W-1:0] gen_target,
   input  logic             stop,
   input  logic             abort,
   input  logic             row_ack,
   output logic             calc_req,
   output logic [ROW_W-1:0] calc_row,
   output logic             bank_sel,
   output logic             busy,
   output logic             gen_done,
   output logic             done,
   output logic [GEN_W-1:0] gen_count
);

   localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [ROW_W-1:0]   LAST_ROW   = ROW_W'(ROWS - 1);
   localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      SWAP  = 2'd3
   } state_t;

   state_t             state_r;
   logic               mode_r;
   logic [GEN_W-1:0]   target_r;
   logic [GEN_W-1:0]   run_cnt_r;
   logic [DRAIN_W-1:0] drain_cnt_r;
   logic [GEN_W-1:0]   run_next_s;
   logic               continue_s;

   // Saturating next run count and the decision to chain another generation.
   always_comb begin
      run_next_s = run_cnt_r;
      continue_s = 1'b0;
      if (&run_cnt_r) begin
         run_next_s = run_cnt_r;
      end else begin
         run_next_s = run_cnt_r + GEN_W'(1);
      end
      continue_s = mode_r && !stop && ((target_r == {GEN_W{1'b0}}) || (run_next_s < target_r));
   end

   // Sequencer state machine with all outputs registered.
   always_ff @(posedge out_stream_aclk) begin
      if (rst) begin
         state_r     <= IDLE;
         mode_r      <= 1'b0;
         target_r    <= {GEN_W{1'b0}};
         run_cnt_r   <= {GEN_W{1'b0}};
         drain_cnt_r <= {DRAIN_W{1'b0}};
         calc_req    <= 1'b0;
         calc_row    <= {ROW_W{1'b0}};
         bank_sel    <= 1'b0;
         busy        <= 1'b0;
         gen_done    <= 1'b0;
         done        <= 1'b0;
         gen_count   <= {GEN_W{1'b0}};
      end else begin
         gen_done <= 1'b0;
         done     <= 1'b0;
         if (abort) begin
            // Abort wins over any handshake or swap in flight.
            state_r  <= IDLE;
            calc_req <= 1'b0;
            calc_row <= {ROW_W{1'b0}};
            busy     <= 1'b0;
         end else begin
            case (state_r)
               IDLE: begin
                  if (start) begin
                     mode_r    <= mode;
                     target_r  <= gen_target;
                     run_cnt_r <= {GEN_W{1'b0}};
                     calc_row  <= {ROW_W{1'b0}};
                     calc_req  <= 1'b1;
                     busy      <= 1'b1;
                     state_r   <= RUN;
                  end
               end
               RUN: begin
                  if (row_ack) begin
                     if (calc_row == LAST_ROW) begin
                        calc_row    <= {ROW_W{1'b0}};
                        calc_req    <= 1'b0;
                        drain_cnt_r <= DRAIN_LOAD;
                        state_r     <= DRAIN;
                     end else begin
                        calc_row <= calc_row + ROW_W'(1);
                     end
                  end
               end
               DRAIN: begin
                  if (drain_cnt_r == {DRAIN_W{1'b0}}) begin
                     state_r <= SWAP;
                  end else begin
                     drain_cnt_r <= drain_cnt_r - DRAIN_W'(1);
                  end
               end
               SWAP: begin
                  bank_sel  <= ~bank_sel;
                  gen_count <= gen_count + GEN_W'(1);
                  run_cnt_r <= run_next_s;
                  gen_done  <= 1'b1;
                  if (continue_s) begin
                     calc_row <= {ROW_W{1'b0}};
                     calc_req <= 1'b1;
                     state_r  <= RUN;
                  end else begin
                     done     <= 1'b1;
                     busy     <= 1'b0;
                     state_r  <= IDLE;
                  end
               end
               default: begin
                  state_r  <= IDLE;
                  calc_req <= 1'b0;
                  busy     <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
